// File: rtl/instr_stream_gen.sv
// instr_stream_gen: program/beta memory sequencer streaming over AXI-Stream.
// Define INSTR_STREAM_GEN_LOOP_EN to honour loop_count (multi-pass playback).
module instr_stream_gen #(
    parameter int NUM_BITS   = 16,
    parameter int PROG_DEPTH = 1024,
    parameter int BETA_DEPTH = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic                wr_sel,
    input  logic [15:0]         wr_addr,
    input  logic [15:0]         wr_data,
    input  logic [15:0]         prog_len,
    input  logic [15:0]         beta_len,
    input  logic [15:0]         loop_count,
    input  logic                start,
    input  logic                abort,
    output logic [15:0]         instr_tdata,
    output logic                instr_tvalid,
    input  logic                instr_tready,
    output logic [NUM_BITS-1:0] b_tdata,
    output logic                b_tvalid,
    input  logic                b_tready,
    output logic                halt,
    output logic                busy,
    output logic                wr_err,
    output logic [31:0]         instr_count
);
    localparam int PAW = $clog2(PROG_DEPTH);
    localparam int BAW = $clog2(BETA_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_PRIME, S_STREAM, S_DRAIN, S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [15:0]         imem [PROG_DEPTH];
    logic [NUM_BITS-1:0] bmem [BETA_DEPTH];

    logic                start_q;
    logic [15:0]         plen_q, blen_q;
    logic [15:0]         iaddr_q, baddr_q;
    logic [15:0]         ibuf_q [2];
    logic [NUM_BITS-1:0] bbuf_q [2];
    logic                ihead_q, itail_q, bhead_q, btail_q;
    logic [1:0]          icnt_q, bcnt_q;
    logic                wr_err_q;
    logic [31:0]         count_q;

    logic start_rise, active, streaming, flush;
    logic ipop, bpop, ird, brd, iwrap, bwrap;
    logic last_pass, last_issue;
    logic unused_bits;

`ifdef INSTR_STREAM_GEN_LOOP_EN
    logic [15:0] pass_q, loops_q;

    assign last_pass = (pass_q >= loops_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pass_q  <= '0;
            loops_q <= '0;
        end else if (state_q == S_IDLE && start_rise) begin
            pass_q  <= 16'd1;
            loops_q <= (loop_count == 16'd0) ? 16'd1 : loop_count;
        end else if (ird && iwrap) begin
            pass_q <= pass_q + 16'd1;
        end
    end
`else
    logic [15:0] unused_loop;

    assign last_pass   = 1'b1;
    assign unused_loop = loop_count;
`endif

    assign start_rise = start && !start_q;
    assign active     = (state_q == S_PRIME) || (state_q == S_STREAM)
                     || (state_q == S_DRAIN);
    assign streaming  = (state_q == S_STREAM) || (state_q == S_DRAIN);

    assign instr_tvalid = streaming && (icnt_q != 2'd0);
    assign b_tvalid     = streaming && (bcnt_q != 2'd0);
    assign instr_tdata  = instr_tvalid ? ibuf_q[ihead_q] : '0;
    assign b_tdata      = b_tvalid ? bbuf_q[bhead_q] : '0;

    assign ipop       = instr_tvalid && instr_tready;
    assign bpop       = b_tvalid && b_tready;
    assign iwrap      = (iaddr_q == plen_q - 16'd1);
    assign bwrap      = (baddr_q == blen_q - 16'd1);
    assign last_issue = iwrap && last_pass;

    // Read only when the 2-entry buffer is guaranteed a free slot next cycle
    assign ird = ((state_q == S_PRIME) || (state_q == S_STREAM)) && !abort
              && (icnt_q != 2'd2 || ipop);
    assign brd = active && !abort && (blen_q != 16'd0)
              && (bcnt_q != 2'd2 || bpop);

    assign flush       = (state_d == S_DONE) && (state_q != S_DONE);
    assign halt        = (state_q == S_DONE);
    assign busy        = active;
    assign wr_err      = wr_err_q;
    assign instr_count = count_q;
    assign unused_bits = ^{wr_addr, wr_data};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_rise)
                    state_d = (prog_len == 16'd0) ? S_DONE : S_PRIME;
            end
            S_PRIME: begin
                if (abort)           state_d = S_DONE;
                else if (last_issue) state_d = S_DRAIN;
                else                 state_d = S_STREAM;
            end
            S_STREAM: begin
                if (abort)                  state_d = S_DONE;
                else if (ird && last_issue) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (abort || (ipop && icnt_q == 2'd1)) state_d = S_DONE;
            end
            S_DONE: begin
                if (!start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            if (wr_sel) bmem[wr_addr[BAW-1:0]] <= wr_data[NUM_BITS-1:0];
            else        imem[wr_addr[PAW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            start_q   <= 1'b0;
            plen_q    <= '0;
            blen_q    <= '0;
            iaddr_q   <= '0;
            baddr_q   <= '0;
            ibuf_q[0] <= '0;
            ibuf_q[1] <= '0;
            bbuf_q[0] <= '0;
            bbuf_q[1] <= '0;
            ihead_q   <= 1'b0;
            itail_q   <= 1'b0;
            bhead_q   <= 1'b0;
            btail_q   <= 1'b0;
            icnt_q    <= '0;
            bcnt_q    <= '0;
            wr_err_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            if (wr_en && busy) wr_err_q <= 1'b1;
            if (state_q == S_IDLE && start_rise) begin
                plen_q   <= prog_len;
                blen_q   <= beta_len;
                iaddr_q  <= '0;
                baddr_q  <= '0;
                wr_err_q <= 1'b0;
                count_q  <= '0;
            end else if (ipop && count_q != '1) begin
                count_q <= count_q + 32'd1;
            end
            if (ird) begin
                ibuf_q[itail_q] <= imem[iaddr_q[PAW-1:0]];
                itail_q         <= ~itail_q;
                iaddr_q         <= iwrap ? '0 : iaddr_q + 16'd1;
            end
            if (brd) begin
                bbuf_q[btail_q] <= bmem[baddr_q[BAW-1:0]];
                btail_q         <= ~btail_q;
                baddr_q         <= bwrap ? '0 : baddr_q + 16'd1;
            end
            if (ipop) ihead_q <= ~ihead_q;
            if (bpop) bhead_q <= ~bhead_q;
            icnt_q <= icnt_q + {1'b0, ird} - {1'b0, ipop};
            bcnt_q <= bcnt_q + {1'b0, brd} - {1'b0, bpop};
            // Undelivered prefetched words are dropped on the way to DONE
            if (flush) begin
                ihead_q <= 1'b0;
                itail_q <= 1'b0;
                bhead_q <= 1'b0;
                btail_q <= 1'b0;
                icnt_q  <= '0;
                bcnt_q  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_instr_stream_gen.sv
// tb_instr_stream_gen: directed tests for instr_stream_gen.
// Words, beta samples and timing are compared against hand-computed values.
module tb_instr_stream_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic        wr_sel = 1'b0;
    logic [15:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [15:0] prog_len = '0;
    logic [15:0] beta_len = '0;
    logic [15:0] loop_count = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] instr_tdata;
    logic        instr_tvalid;
    logic        instr_tready = 1'b0;
    logic [15:0] b_tdata;
    logic        b_tvalid;
    logic        b_tready = 1'b0;
    logic        halt;
    logic        busy;
    logic        wr_err;
    logic [31:0] instr_count;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] iq [$];
    logic [15:0] bq [$];
    int          first_cyc;
    int          halt_cyc;
    int          viol;
    bit          timeout;
    logic [15:0] bexp [3] = '{16'h0010, 16'h0020, 16'h0030};

    instr_stream_gen #(
        .NUM_BITS  (16),
        .PROG_DEPTH(64),
        .BETA_DEPTH(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .prog_len    (prog_len),
        .beta_len    (beta_len),
        .loop_count  (loop_count),
        .start       (start),
        .abort       (abort),
        .instr_tdata (instr_tdata),
        .instr_tvalid(instr_tvalid),
        .instr_tready(instr_tready),
        .b_tdata     (b_tdata),
        .b_tvalid    (b_tvalid),
        .b_tready    (b_tready),
        .halt        (halt),
        .busy        (busy),
        .wr_err      (wr_err),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic sel, input logic [15:0] a,
                      input logic [15:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_sel = sel; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Starts a run (start high at cycle 0) and records handshakes until halt.
    task automatic run_capture(input logic [15:0] pl, input logic [15:0] bl,
                               input logic [15:0] lc, input bit itog,
                               input bit btog);
        int cyc = 0;
        bit istall = 0;
        bit bstall = 0;
        logic [15:0] ihold = '0;
        logic [15:0] bhold = '0;
        iq.delete(); bq.delete();
        viol = 0; timeout = 0; first_cyc = -1; halt_cyc = -1;
        @(negedge clk);
        prog_len = pl; beta_len = bl; loop_count = lc;
        instr_tready = 1'b1; b_tready = 1'b1; start = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (halt) begin halt_cyc = cyc; break; end
            if (cyc > 300) begin timeout = 1; break; end
            if (itog) instr_tready = ~instr_tready;
            if (btog) b_tready = ~b_tready;
            if (istall && (!instr_tvalid || instr_tdata !== ihold)) viol++;
            if (bstall && (!b_tvalid || b_tdata !== bhold)) viol++;
            if (instr_tvalid && first_cyc < 0) first_cyc = cyc;
            if (instr_tvalid && instr_tready) iq.push_back(instr_tdata);
            if (b_tvalid && b_tready) bq.push_back(b_tdata);
            istall = instr_tvalid && !instr_tready; ihold = instr_tdata;
            bstall = b_tvalid && !b_tready;         bhold = b_tdata;
        end
        instr_tready = 1'b1; b_tready = 1'b1;
    endtask

    task automatic finish_run();
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({instr_tvalid, b_tvalid, halt, busy, wr_err} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_flags got=%b exp=00000",
                     {instr_tvalid, b_tvalid, halt, busy, wr_err});
        end
        n_checks++;
        if (instr_count !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_count got=%0d exp=0", instr_count);
        end
        n_checks++;
        if (instr_tdata !== 16'd0 || b_tdata !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_tdata got=%h/%h exp=0/0", instr_tdata, b_tdata);
        end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        run_capture(16'd8, 16'd3, 16'd1, 1'b0, 1'b0);
        n_checks++;
        if (timeout) begin n_errors++; $display("FAIL basic_timeout got=1 exp=0"); end
        n_checks++;
        if (first_cyc !== 2) begin
            n_errors++; $display("FAIL basic_latency got=%0d exp=2", first_cyc);
        end
        n_checks++;
        if (halt_cyc !== 10) begin
            n_errors++; $display("FAIL basic_halt_cyc got=%0d exp=10", halt_cyc);
        end
        n_checks++;
        if (iq.size() !== 8) begin
            n_errors++; $display("FAIL basic_nwords got=%0d exp=8", iq.size());
        end
        for (int i = 0; i < iq.size() && i < 8; i++) begin
            n_checks++;
            if (iq[i] !== 16'(i + 1)) begin
                n_errors++;
                $display("FAIL basic_word%0d got=%h exp=%h", i, iq[i], 16'(i + 1));
            end
        end
        n_checks++;
        if (bq.size() !== 8) begin
            n_errors++; $display("FAIL basic_nbeta got=%0d exp=8", bq.size());
        end
        for (int i = 0; i < bq.size() && i < 8; i++) begin
            n_checks++;
            if (bq[i] !== bexp[i % 3]) begin
                n_errors++;
                $display("FAIL basic_beta%0d got=%h exp=%h", i, bq[i], bexp[i % 3]);
            end
        end
        n_checks++;
        if (instr_tvalid !== 1'b0 || b_tvalid !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_done_flags got=%b%b%b exp=000",
                     instr_tvalid, b_tvalid, busy);
        end
        n_checks++;
        if (instr_count !== 32'd8) begin
            n_errors++; $display("FAIL basic_count got=%0d exp=8", instr_count);
        end
        finish_run();
        n_checks++;
        if (halt !== 1'b0) begin
            n_errors++; $display("FAIL basic_halt_drop got=%b exp=0", halt);
        end
    endtask

    task automatic test_toggle();
        run_capture(16'd8, 16'd3, 16'd1, 1'b1, 1'b0);
        n_checks++;
        if (timeout || viol !== 0) begin
            n_errors++;
            $display("FAIL toggle_stable got=to%0d/viol%0d exp=to0/viol0", timeout, viol);
        end
        n_checks++;
        if (halt_cyc !== 17) begin
            n_errors++; $display("FAIL toggle_halt_cyc got=%0d exp=17", halt_cyc);
        end
        n_checks++;
        if (iq.size() !== 8) begin
            n_errors++; $display("FAIL toggle_nwords got=%0d exp=8", iq.size());
        end
        for (int i = 0; i < iq.size() && i < 8; i++) begin
            n_checks++;
            if (iq[i] !== 16'(i + 1)) begin
                n_errors++;
                $display("FAIL toggle_word%0d got=%h exp=%h", i, iq[i], 16'(i + 1));
            end
        end
        n_checks++;
        if (instr_count !== 32'd8) begin
            n_errors++; $display("FAIL toggle_count got=%0d exp=8", instr_count);
        end
        finish_run();
    endtask

    task automatic test_beta();
        run_capture(16'd16, 16'd3, 16'd1, 1'b0, 1'b1);
        n_checks++;
        if (timeout || viol !== 0) begin
            n_errors++;
            $display("FAIL beta_stable got=to%0d/viol%0d exp=to0/viol0", timeout, viol);
        end
        n_checks++;
        if (bq.size() < 7) begin
            n_errors++; $display("FAIL beta_nsamples got=%0d exp>=7", bq.size());
        end
        for (int i = 0; i < bq.size() && i < 7; i++) begin
            n_checks++;
            if (bq[i] !== bexp[i % 3]) begin
                n_errors++;
                $display("FAIL beta_sample%0d got=%h exp=%h", i, bq[i], bexp[i % 3]);
            end
        end
        n_checks++;
        if (iq.size() !== 16) begin
            n_errors++; $display("FAIL beta_nwords got=%0d exp=16", iq.size());
        end
        finish_run();
    endtask

    task automatic test_loop();
        int nexp;
`ifdef INSTR_STREAM_GEN_LOOP_EN
        nexp = 12;
`else
        nexp = 4;
`endif
        run_capture(16'd4, 16'd3, 16'd3, 1'b0, 1'b0);
        n_checks++;
        if (timeout || iq.size() !== nexp) begin
            n_errors++;
            $display("FAIL loop_nwords got=%0d exp=%0d", iq.size(), nexp);
        end
        for (int i = 0; i < iq.size() && i < nexp; i++) begin
            n_checks++;
            if (iq[i] !== 16'((i % 4) + 1)) begin
                n_errors++;
                $display("FAIL loop_word%0d got=%h exp=%h", i, iq[i], 16'((i % 4) + 1));
            end
        end
        n_checks++;
        if (instr_count !== 32'(nexp)) begin
            n_errors++;
            $display("FAIL loop_count got=%0d exp=%0d", instr_count, nexp);
        end
        finish_run();
    endtask

    task automatic test_zero();
        run_capture(16'd0, 16'd3, 16'd1, 1'b0, 1'b0);
        n_checks++;
        if (halt_cyc !== 1 || first_cyc !== -1) begin
            n_errors++;
            $display("FAIL zero_halt got=cyc%0d/first%0d exp=cyc1/first-1",
                     halt_cyc, first_cyc);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({halt, instr_tvalid, b_tvalid} !== 3'b100) begin
                n_errors++;
                $display("FAIL zero_hold%0d got=%b exp=100", i,
                         {halt, instr_tvalid, b_tvalid});
            end
        end
        n_checks++;
        if (instr_count !== 32'd0) begin
            n_errors++; $display("FAIL zero_count got=%0d exp=0", instr_count);
        end
        finish_run();
        n_checks++;
        if (halt !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_idle got=%b%b exp=00", halt, busy);
        end
    endtask

    task automatic test_abort();
        int hs = 0;
        int cyc = 0;
        bit wrote = 0;
        @(negedge clk);
        prog_len = 16'd16; beta_len = 16'd3; loop_count = 16'd1;
        instr_tready = 1'b1; b_tready = 1'b1; start = 1'b1;
        while (hs < 5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            wr_en = 1'b0;
            if (hs == 2 && !wrote) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_errors++; $display("FAIL abort_busy got=%b exp=1", busy);
                end
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 16'd0; wr_data = 16'hDEAD;
                wrote = 1;
            end
            if (instr_tvalid && instr_tready) hs++;
        end
        n_checks++;
        if (hs !== 5) begin
            n_errors++; $display("FAIL abort_reach5 got=%0d exp=5", hs);
        end
        @(negedge clk);
        n_checks++;
        if (instr_tvalid !== 1'b1) begin
            n_errors++; $display("FAIL abort_pre_valid got=%b exp=1", instr_tvalid);
        end
        instr_tready = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if ({instr_tvalid, b_tvalid, halt} !== 3'b001) begin
            n_errors++;
            $display("FAIL abort_flags got=%b exp=001", {instr_tvalid, b_tvalid, halt});
        end
        n_checks++;
        if (instr_count !== 32'd5) begin
            n_errors++; $display("FAIL abort_count got=%0d exp=5", instr_count);
        end
        n_checks++;
        if (wr_err !== 1'b1) begin
            n_errors++; $display("FAIL abort_wr_err got=%b exp=1", wr_err);
        end
        instr_tready = 1'b1;
        finish_run();
        run_capture(16'd2, 16'd3, 16'd1, 1'b0, 1'b0);
        n_checks++;
        if (iq.size() !== 2 || iq[0] !== 16'h0001) begin
            n_errors++;
            $display("FAIL abort_mem_kept got=n%0d/%h exp=n2/0001", iq.size(), iq[0]);
        end
        n_checks++;
        if (wr_err !== 1'b0) begin
            n_errors++; $display("FAIL abort_wr_err_clr got=%b exp=0", wr_err);
        end
        finish_run();
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        prog_len = 16'd16; beta_len = 16'd3; loop_count = 16'd1;
        instr_tready = 1'b1; b_tready = 1'b1; start = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (instr_count !== 32'd3 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL midrun_pre got=%0d/%b exp=3/1", instr_count, busy);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({instr_tvalid, b_tvalid, halt, busy} !== 4'b0 || instr_count !== 32'd0) begin
            n_errors++;
            $display("FAIL midrun_reset got=%b/%0d exp=0000/0",
                     {instr_tvalid, b_tvalid, halt, busy}, instr_count);
        end
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        run_capture(16'd8, 16'd3, 16'd1, 1'b0, 1'b0);
        n_checks++;
        if (iq.size() !== 8) begin
            n_errors++; $display("FAIL midrun_nwords got=%0d exp=8", iq.size());
        end
        for (int i = 0; i < iq.size() && i < 8; i++) begin
            n_checks++;
            if (iq[i] !== 16'(i + 1)) begin
                n_errors++;
                $display("FAIL midrun_word%0d got=%h exp=%h", i, iq[i], 16'(i + 1));
            end
        end
        finish_run();
    endtask

    initial begin
        test_reset();
        for (int i = 0; i < 16; i++) wr(1'b0, 16'(i), 16'(i + 1));
        for (int i = 0; i < 3; i++)  wr(1'b1, 16'(i), bexp[i]);
        test_basic();
        test_toggle();
        test_beta();
        test_loop();
        test_zero();
        test_abort();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
